// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_tx_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_ARB       = 3'd0,
    ST_SEND      = 3'd1,
    ST_WAIT_ACK  = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_TAG       = 3'd4
  } arbState_t;

  localparam logic [3:0] TAG_NIBBLE = 4'hA;

  // Smallest r with 2**r >= n.
  function automatic int log2Ceil(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      r = ((32'sd1 <<< i) < n) ? (i + 1) : r;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester after ptr (with wrap) wins.
module rr_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) (
  input  logic [N_REQ-1:0]           req,
  input  logic [log2Ceil(N_REQ)-1:0] ptr,
  output logic [log2Ceil(N_REQ)-1:0] gntIdx,
  output logic                       anyReq
);

  localparam int IW = log2Ceil(N_REQ);

  int            cand;
  logic [IW-1:0] candIdx;
  logic          hit;

  // Scan ptr+1 .. ptr+N_REQ; only the first hit is kept.
  always_comb begin
    gntIdx  = '0;
    anyReq  = 1'b0;
    cand    = 0;
    candIdx = '0;
    hit     = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      cand    = (int'(ptr) + off) % N_REQ;
      candIdx = cand[IW-1:0];
      hit     = req[candIdx] & ~anyReq;
      gntIdx  = hit ? candIdx : gntIdx;
      anyReq  = anyReq | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among N_REQ byte-stream requesters with round-robin bursts.
// Define UART_ARB_SRC_TAG_EN to prefix each grant with a source tag byte {4'hA, grant_id}.
module uart_tx_arbiter
  import uart_tx_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int BITS      = 8,
  parameter int MAX_BURST = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  input  logic [N_REQ*BITS-1:0]      req_data,
  input  logic [N_REQ-1:0]           req_last,
  output logic [N_REQ-1:0]           req_ready,
  output logic                       tx_start,
  output logic [BITS-1:0]            tx_data,
  input  logic                       tx_busy,
  output logic                       grant_valid,
  output logic [log2Ceil(N_REQ)-1:0] grant_id
);

  localparam int IW      = log2Ceil(N_REQ);
  localparam int CW      = log2Ceil(MAX_BURST + 1);
  localparam int TAG_LOW = BITS - 4;
  localparam logic [CW-1:0]    BURST_MAX   = CW'(MAX_BURST);
  localparam logic [CW-1:0]    BURST_ONE   = CW'(32'd1);
  localparam logic [N_REQ-1:0] ONE_HOT_LSB = N_REQ'(32'd1);
`ifdef UART_ARB_SRC_TAG_EN
  localparam arbState_t GRANT_STATE = ST_TAG;
`else
  localparam arbState_t GRANT_STATE = ST_SEND;
`endif

  arbState_t       stateR, stateN;
  logic [IW-1:0]   gntIdR, gntIdN, ptrR, ptrN, pickIdx;
  logic            gntValidR, gntValidN;
  logic            lastR, lastN;
  logic            txStartR, txStartN;
  logic [CW-1:0]   burstCntR, burstCntN;
  logic [BITS-1:0] txDataR, txDataN, gntData;
  logic            anyReq, gntValidIn, gntLastIn, fire;

  rr_arbiter #(.N_REQ(N_REQ)) uPick (
    .req    (req_valid),
    .ptr    (ptrR),
    .gntIdx (pickIdx),
    .anyReq (anyReq)
  );

  assign gntData    = req_data[int'(gntIdR)*BITS +: BITS];
  assign gntValidIn = req_valid[gntIdR];
  assign gntLastIn  = req_last[gntIdR];
  assign fire       = (stateR == ST_SEND) && gntValidIn && !tx_busy;

  // Accept strobe: only the owner, only in the cycle its byte is taken.
  always_comb begin
    req_ready = '0;
    if (rst && fire) begin
      req_ready = ONE_HOT_LSB << gntIdR;
    end else begin
      req_ready = '0;
    end
  end

  // Next-state and next-output logic; tx_start is a one-cycle pulse by default-low.
  always_comb begin
    stateN    = stateR;
    gntIdN    = gntIdR;
    gntValidN = gntValidR;
    ptrN      = ptrR;
    burstCntN = burstCntR;
    lastN     = lastR;
    txStartN  = 1'b0;
    txDataN   = txDataR;
    case (stateR)
      ST_ARB: begin
        if (anyReq) begin
          gntIdN    = pickIdx;
          gntValidN = 1'b1;
          burstCntN = '0;
          lastN     = 1'b0;
          stateN    = GRANT_STATE;
        end else begin
          gntValidN = 1'b0;
        end
      end
      ST_TAG: begin
        // The tag leaves last and the burst count clear, so WAIT_DONE returns to SEND.
        if (!tx_busy) begin
          txStartN = 1'b1;
          txDataN  = {TAG_NIBBLE, TAG_LOW'(gntIdR)};
          stateN   = ST_WAIT_ACK;
        end else begin
          stateN = ST_TAG;
        end
      end
      ST_SEND: begin
        if (!gntValidIn) begin
          gntValidN = 1'b0;
          ptrN      = gntIdR;
          stateN    = ST_ARB;
        end else if (!tx_busy) begin
          txStartN  = 1'b1;
          txDataN   = gntData;
          lastN     = gntLastIn;
          burstCntN = burstCntR + BURST_ONE;
          stateN    = ST_WAIT_ACK;
        end else begin
          stateN = ST_SEND;
        end
      end
      ST_WAIT_ACK: begin
        if (tx_busy) begin
          stateN = ST_WAIT_DONE;
        end else begin
          stateN = ST_WAIT_ACK;
        end
      end
      ST_WAIT_DONE: begin
        if (tx_busy) begin
          stateN = ST_WAIT_DONE;
        end else if (lastR || (burstCntR == BURST_MAX)) begin
          gntValidN = 1'b0;
          ptrN      = gntIdR;
          stateN    = ST_ARB;
        end else begin
          stateN = ST_SEND;
        end
      end
      default: begin
        gntValidN = 1'b0;
        stateN    = ST_ARB;
      end
    endcase
  end

  // State and output registers; the pointer resets to N_REQ-1 so requester 0 wins first.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateR    <= ST_ARB;
      gntIdR    <= '0;
      gntValidR <= 1'b0;
      ptrR      <= IW'(N_REQ - 1);
      burstCntR <= '0;
      lastR     <= 1'b0;
      txStartR  <= 1'b0;
      txDataR   <= '0;
    end else begin
      stateR    <= stateN;
      gntIdR    <= gntIdN;
      gntValidR <= gntValidN;
      ptrR      <= ptrN;
      burstCntR <= burstCntN;
      lastR     <= lastN;
      txStartR  <= txStartN;
      txDataR   <= txDataN;
    end
  end

  assign tx_start    = txStartR;
  assign tx_data     = txDataR;
  assign grant_valid = gntValidR;
  assign grant_id    = gntIdR;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: transaction-level model of grant order and transmitted bytes,
// checked every cycle, plus literal per-scenario totals.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int N        = 4;
  localparam int B        = 8;
  localparam int MB       = 4;
  localparam int BUSY_CYC = 10;
  localparam int BUDGET   = 4000;
`ifdef UART_ARB_SRC_TAG_EN
  localparam int TAGB = 1;
`else
  localparam int TAGB = 0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] req_valid, req_last, req_ready;
  logic [N*B-1:0] req_data;
  logic         tx_start, tx_busy, grant_valid;
  logic [B-1:0] tx_data;
  logic [1:0]   grant_id;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.N_REQ(N), .BITS(B), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_valid(grant_valid),
    .grant_id(grant_id)
  );

  logic [8:0] reqQ [N][$];   // {last, data} per requester
  logic [8:0] mq   [N][$];
  logic [7:0] expTx [$];
  int         expGnt [$];
  int tests = 0, fails = 0;
  int mPtr, busyCnt = 0;
  int txCnt = 0, txSum = 0, rdyCnt = 0, gntSeq = 0;
  logic prevStart, prevGv;
  logic [7:0] lastData;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic bit allEmpty();
    bit e;
    e = 1'b1;
    for (int k = 0; k < N; k++) e = e && (reqQ[k].size() == 0);
    return e;
  endfunction

  task automatic driveReqs();
    logic [8:0] h;
    for (int k = 0; k < N; k++) begin
      if (reqQ[k].size() > 0) begin
        h = reqQ[k][0];
        req_valid[k] = 1'b1;
        req_data[k*B +: B] = h[7:0];
        req_last[k] = h[8];
      end else begin
        req_valid[k] = 1'b0;
        req_data[k*B +: B] = 8'h00;
        req_last[k] = 1'b0;
      end
    end
  endtask

  // Spec-level model: round-robin over non-empty streams, burst ends on last, MAX_BURST or empty stream.
  task automatic modelRun();
    int g, c, sent;
    bit more, done;
    logic [8:0] b;
    for (int k = 0; k < N; k++) mq[k] = reqQ[k];
    more = 1'b1;
    while (more) begin
      g = -1;
      for (int off = 1; off <= N; off++) begin
        c = (mPtr + off) % N;
        if (g < 0 && mq[c].size() > 0) g = c;
      end
      if (g < 0) begin
        more = 1'b0;
      end else begin
        expGnt.push_back(g);
        if (TAGB == 1) expTx.push_back(8'hA0 + 8'(g));
        sent = 0;
        done = 1'b0;
        while (!done) begin
          if (mq[g].size() == 0) begin
            done = 1'b1;
          end else begin
            b = mq[g].pop_front();
            expTx.push_back(b[7:0]);
            sent++;
            if (b[8] || sent == MB) done = 1'b1;
          end
        end
        mPtr = g;
      end
    end
  endtask

  task automatic load(input int k, input logic [7:0] d, input logic l);
    reqQ[k].push_back({l, d});
  endtask

  task automatic startScenario();
    txCnt = 0; txSum = 0; rdyCnt = 0; gntSeq = 0;
  endtask

  task automatic finishScenario(input string name, input int seq, input int ntx,
                                input int sum, input int nrdy);
    int cyc;
    cyc = 0;
    while (cyc < BUDGET && !(allEmpty() && !grant_valid && !tx_busy && expTx.size() == 0)) begin
      @(negedge clk);
      cyc++;
    end
    repeat (3) @(negedge clk);
    check({name, "_in_budget"}, int'(cyc < BUDGET), 1);
    check({name, "_grant_seq"}, gntSeq, seq);
    check({name, "_tx_count"}, txCnt, ntx);
    check({name, "_tx_sum"}, txSum, sum);
    check({name, "_ready_count"}, rdyCnt, nrdy);
    check({name, "_grants_left"}, expGnt.size(), 0);
  endtask

  // Requester streams and transmitter: handshakes sampled mid-cycle, applied after the edge.
  initial begin
    logic [N-1:0] acc;
    logic st;
    logic [8:0] h;
    #1;
    tx_busy = 1'b0;
    driveReqs();
    forever begin
      @(negedge clk);
      acc = req_ready;
      st  = tx_start;
      @(posedge clk);
      #1;
      for (int k = 0; k < N; k++) begin
        if (acc[k] && reqQ[k].size() > 0) h = reqQ[k].pop_front();
      end
      if (st) busyCnt = BUSY_CYC;
      if (busyCnt > 0) begin
        tx_busy = 1'b1;
        busyCnt--;
      end else begin
        tx_busy = 1'b0;
      end
      driveReqs();
    end
  end

  // Compare process: every out-of-reset cycle against the model and the handshake rules.
  initial begin
    prevStart = 1'b0; prevGv = 1'b0; lastData = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prevStart = 1'b0; prevGv = 1'b0; lastData = 8'h00;
      end else begin
        if (tx_start) begin
          check("tx_start_single_cycle", prevStart, 0);
          check("tx_frame_expected", int'(expTx.size() > 0), 1);
          if (expTx.size() > 0) check("tx_data", tx_data, expTx.pop_front());
          txCnt++;
          txSum += tx_data;
          lastData = tx_data;
        end else begin
          check("tx_data_stable", tx_data, lastData);
        end
        if (req_ready != 4'b0000) begin
          check("ready_onehot", $countones(req_ready), 1);
          check("ready_owner", int'(req_ready), grant_valid ? (32'd1 << grant_id) : 32'd0);
          rdyCnt++;
        end
        if (grant_valid && !prevGv) begin
          check("grant_expected", int'(expGnt.size() > 0), 1);
          if (expGnt.size() > 0) check("grant_id", grant_id, expGnt.pop_front());
          gntSeq = gntSeq * 16 + int'(grant_id) + 1;
        end
        prevStart = tx_start;
        prevGv    = grant_valid;
      end
    end
  end

  initial begin
    rst  = 1'b0;
    mPtr = N - 1;

    // Reset with every requester offering one final byte.
    startScenario();
    for (int k = 0; k < N; k++) load(k, 8'hC0 + 8'(k), 1'b1);
    modelRun();
    repeat (2) @(negedge clk);
    check("rst_tx_start", tx_start, 0);
    check("rst_tx_data", tx_data, 0);
    check("rst_grant_valid", grant_valid, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_req_ready", req_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    check("first_grant_valid", grant_valid, 1);
    check("first_grant_id", grant_id, 0);
    finishScenario("reset", 32'h1234, 4 + 4*TAGB, 32'h306 + TAGB*32'h286, 4);

    // Round-robin: 0, 1, 3 each with two single-byte bursts.
    startScenario();
    load(0, 8'h01, 1'b1); load(0, 8'h02, 1'b1);
    load(1, 8'h10, 1'b1); load(1, 8'h20, 1'b1);
    load(3, 8'h30, 1'b1); load(3, 8'h40, 1'b1);
    modelRun();
    finishScenario("round_robin", 32'h124124, 6 + 6*TAGB, 32'hA3 + TAGB*32'h3C8, 6);

    // MAX_BURST=4: requester 1 streams 10 bytes with no last.
    startScenario();
    for (int i = 0; i < 10; i++) load(1, 8'h61 + 8'(i), 1'b0);
    modelRun();
    finishScenario("max_burst", 32'h222, 10 + 3*TAGB, 32'h3F7 + TAGB*32'h1E3, 10);

    // Single burst from requester 2.
    startScenario();
    load(2, 8'h11, 1'b0); load(2, 8'h22, 1'b0); load(2, 8'h33, 1'b1);
    modelRun();
    finishScenario("single_burst", 32'h3, 3 + TAGB, 32'h66 + TAGB*32'hA2, 3);

    // Requester 0 drops valid after two bytes while requester 2 waits.
    startScenario();
    load(0, 8'hA1, 1'b0); load(0, 8'hA2, 1'b0);
    load(2, 8'hB1, 1'b0); load(2, 8'hB2, 1'b1);
    modelRun();
    finishScenario("valid_drop", 32'h13, 4 + 2*TAGB, 32'h2A6 + TAGB*32'h142, 4);

    // Requester 3 sends one final byte (tag 0xA3 precedes it in the tagged build).
    startScenario();
    load(3, 8'h5A, 1'b1);
    modelRun();
    finishScenario("tag_req3", 32'h4, 1 + TAGB, 32'h5A + TAGB*32'hA3, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
